// File: rtl/vgastripes_pkg.sv
// Shared definitions for the stripe toggle path: measurement FSM states and
// the default counter width used by the toggle period meter.
package vgastripes_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meas_state_e;

    // 28 bits covers a 120 M-cycle stripe toggle period with headroom.
    localparam int STRIPE_CNT_W = 28;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level plus a history flop,
// producing single-cycle rise/fall strobes in the clk1 domain.
module sync_edge_detect (
    input  logic clk1,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= sig_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Both strobes come from the same s2/prev pair, so they never coincide.
    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures period and high time of a slow asynchronous toggle in clk1 cycles,
// one result per accepted rise, with glitch rejection and loss-of-signal flag.
module toggle_period_meter
    import vgastripes_pkg::*;
#(
    parameter int CNT_W      = STRIPE_CNT_W,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_cnt;
    meas_state_e      state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    sync_edge_detect u_sync (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    // Counter, FSM and result registers; one cycle after the rise/fall strobes.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            high_cnt     <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (clr) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                high_cnt  <= '0;
                period    <= '0;
                high_time <= '0;
                locked    <= 1'b0;
                timeout   <= 1'b0;
            end else begin
                cnt <= sat_inc(cnt);
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            cnt      <= CNT_ONE;
                            high_cnt <= '0;
                            timeout  <= 1'b0;
                            state    <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (fall) begin
                            high_cnt <= cnt;
                        end
                        // An accepted rise at saturation still yields a result.
                        if (rise && (cnt >= CNT_MIN)) begin
                            period       <= cnt;
                            high_time    <= high_cnt;
                            period_valid <= 1'b1;
                            locked       <= 1'b1;
                            cnt          <= CNT_ONE;
                            high_cnt     <= '0;
                        end else if (cnt == CNT_MAX) begin
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Directed bench for toggle_period_meter with CNT_W=8, MIN_PERIOD=4.
module tb_toggle_period_meter;

    localparam int CNT_W = 8;

    logic             clk1;
    logic             rst_n;
    logic             sig_in;
    logic             clr;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    logic sig_drv;
    logic div_en;
    logic div_q;
    int   div_cnt;
    int   pv_total;
    int   base;
    int   vectors;
    int   miscompares;

    toggle_period_meter #(.CNT_W(CNT_W), .MIN_PERIOD(4)) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .clr          (clr),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    assign sig_in = div_en ? div_q : sig_drv;

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Stand-in for the stripe toggle divider with half-count 10.
    initial begin
        div_q   = 1'b0;
        div_cnt = 0;
    end
    always @(negedge clk1) begin
        if (div_en) begin
            if (div_cnt == 9) begin
                div_cnt = 0;
                div_q   = ~div_q;
            end else begin
                div_cnt = div_cnt + 1;
            end
        end
    end

    initial pv_total = 0;
    always @(negedge clk1) begin
        if (period_valid) pv_total = pv_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic put(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk1);
            sig_drv = v;
        end
    endtask

    task automatic square(input int n);
        for (int i = 0; i < n; i++) begin
            put(1'b1, 8);
            put(1'b0, 12);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clr         = 1'b0;
        sig_drv     = 1'b0;
        div_en      = 1'b0;
        repeat (3) @(negedge clk1);
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_pv", period_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        // Steady 20/8 square wave: first rise only arms.
        #1 base = pv_total;
        square(5);
        #1;
        chk("sq_pulses", pv_total - base, 4);
        chk("sq_period", period, 20);
        chk("sq_high", high_time, 8);
        chk("sq_locked", locked, 1);
        chk("sq_timeout", timeout, 0);

        // Spacing of exactly MIN_PERIOD is accepted.
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 2);
            put(1'b0, 2);
        end
        #1;
        chk("min_period", period, 4);
        chk("min_high", high_time, 2);

        // Loss of signal.
        square(1);
        put(1'b1, 8);
        put(1'b0, 240);
        #1;
        chk("los_early_timeout", timeout, 0);
        chk("los_early_locked", locked, 1);
        put(1'b0, 20);
        #1;
        chk("los_timeout", timeout, 1);
        chk("los_locked", locked, 0);
        chk("los_period_hold", period, 20);
        chk("los_high_hold", high_time, 8);
        #1 base = pv_total;
        square(1);
        #1;
        chk("rearm_timeout", timeout, 0);
        chk("rearm_locked", locked, 0);
        chk("rearm_pulses", pv_total - base, 0);
        square(1);
        #1;
        chk("relock_pulses", pv_total - base, 1);
        chk("relock_locked", locked, 1);
        chk("relock_period", period, 20);

        // Glitch two cycles after a rise.
        #1 base = pv_total;
        put(1'b1, 1);
        put(1'b0, 1);
        put(1'b1, 1);
        put(1'b0, 17);
        square(1);
        #1;
        chk("glitch_pulses", pv_total - base, 2);
        chk("glitch_period", period, 20);
        chk("glitch_high", high_time, 3);

        // clr coincident with a rise.
        #1 base = pv_total;
        @(negedge clk1) sig_drv = 1'b1;
        @(negedge clk1);
        @(negedge clk1) clr = 1'b1;
        @(negedge clk1) clr = 1'b0;
        put(1'b1, 4);
        put(1'b0, 12);
        #1;
        chk("clr_pulses", pv_total - base, 0);
        chk("clr_period", period, 0);
        chk("clr_high", high_time, 0);
        chk("clr_locked", locked, 0);
        chk("clr_timeout", timeout, 0);
        square(1);
        #1;
        chk("clr_arm_pulses", pv_total - base, 0);
        square(1);
        #1;
        chk("clr_next_pulses", pv_total - base, 1);
        chk("clr_next_period", period, 20);
        chk("clr_next_high", high_time, 8);

        // Asynchronous reset between clock edges.
        put(1'b1, 8);
        put(1'b0, 5);
        @(posedge clk1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_period", period, 0);
        chk("arst_high", high_time, 0);
        chk("arst_locked", locked, 0);
        chk("arst_pv", period_valid, 0);
        chk("arst_timeout", timeout, 0);
        #1 rst_n = 1'b1;
        base = pv_total;
        put(1'b0, 7);
        square(1);
        #1;
        chk("arst_arm_pulses", pv_total - base, 0);
        square(1);
        #1;
        chk("arst_next_pulses", pv_total - base, 1);
        chk("arst_next_period", period, 20);

        // Driven from the toggle divider, half-count 10.
        sig_drv = 1'b0;
        div_en  = 1'b1;
        repeat (60) @(negedge clk1);
        #1 base = pv_total;
        repeat (100) @(negedge clk1);
        #1;
        chk("div_pulses", pv_total - base, 5);
        chk("div_period", period, 20);
        chk("div_high", high_time, 10);
        chk("div_locked", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
